// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA drawing constants and the frame-sync FSM state type.
// Rev 1.0
`default_nettype none

package vga_pkg;

  // Rectangle footprint, used to keep the drawn rectangle fully on screen.
  localparam int WIDTH  = 47;
  localparam int LENGHT = 63;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_COMMIT = 2'd1,
    ST_BLANK  = 2'd2
  } pos_state_t;

endpackage

`default_nettype wire

// File: rtl/vga_if.sv
// vga_if: VGA timing bus; the position sync only consumes vblnk.
// Rev 1.0
`default_nettype none

interface vga_if;
  logic vblnk;

  modport in  (input  vblnk);
  modport out (output vblnk);
endinterface

`default_nettype wire

// File: rtl/pos_step.sv
// pos_step: moves one coordinate toward its target by at most MAX_STEP pixels.
// Rev 1.0
`default_nettype none

module pos_step #(
  parameter int MAX_STEP = 16
) (
  input  logic [11:0] current,
  input  logic [11:0] target,
  output logic [11:0] next
);

  localparam logic signed [12:0] c_STEP     = 13'(MAX_STEP);
  localparam logic        [11:0] c_STEP_U12 = 12'(MAX_STEP);

  logic signed [12:0] w_diff;

  assign w_diff = $signed({1'b0, target}) - $signed({1'b0, current});

  // Stepping toward the target never overshoots it, so 12-bit results cannot wrap.
  always_comb begin
    next = target;
    if (w_diff > c_STEP) begin
      next = current + c_STEP_U12;
    end else if (w_diff < -c_STEP) begin
      next = current - c_STEP_U12;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mouse_pos_sync.sv
// mouse_pos_sync: latches mouse samples and commits rate-limited positions once per vblank.
// Optional macro POS_CLAMP_EN clamps captured targets to keep the rectangle on screen. Rev 1.0
`default_nettype none

module mouse_pos_sync
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int MAX_STEP = 16
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vga_in,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_valid,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        frame_upd
);

`ifdef POS_CLAMP_EN
  localparam bit c_CLAMP_EN = 1'b1;
`else
  localparam bit c_CLAMP_EN = 1'b0;
`endif

  localparam logic [11:0] c_X_MAX = 12'(H_ACTIVE - 1 - WIDTH);
  localparam logic [11:0] c_Y_MAX = 12'(V_ACTIVE - 1 - LENGHT);

  pos_state_t  r_state, w_state_nxt;
  logic [11:0] r_tgt_x, r_tgt_y;
  logic [11:0] r_xpos, r_ypos;
  logic        r_frame_upd;
  logic        r_vblnk_d;
  logic        r_armed;
  logic [11:0] w_cap_x, w_cap_y;
  logic [11:0] w_next_x, w_next_y;
  logic        w_commit_pt;

  assign w_cap_x = (c_CLAMP_EN && (mouse_xpos > c_X_MAX)) ? c_X_MAX : mouse_xpos;
  assign w_cap_y = (c_CLAMP_EN && (mouse_ypos > c_Y_MAX)) ? c_Y_MAX : mouse_ypos;

  // r_armed blocks a false commit when reset releases while vblnk is already high.
  assign w_commit_pt = vga_in.vblnk & ~r_vblnk_d & r_armed;

  pos_step #(.MAX_STEP(MAX_STEP)) u_step_x (
    .current (r_xpos),
    .target  (r_tgt_x),
    .next    (w_next_x)
  );

  pos_step #(.MAX_STEP(MAX_STEP)) u_step_y (
    .current (r_ypos),
    .target  (r_tgt_y),
    .next    (w_next_y)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACTIVE: if (w_commit_pt) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_BLANK;
      ST_BLANK:  if (!vga_in.vblnk) w_state_nxt = ST_ACTIVE;
      default:   w_state_nxt = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_ACTIVE;
      r_vblnk_d   <= 1'b0;
      r_armed     <= 1'b0;
      r_tgt_x     <= '0;
      r_tgt_y     <= '0;
      r_xpos      <= '0;
      r_ypos      <= '0;
      r_frame_upd <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_vblnk_d <= vga_in.vblnk;
      r_armed   <= r_armed | ~vga_in.vblnk;
      // Step math reads the old target, so a sample landing in COMMIT waits a frame.
      if (mouse_valid) begin
        r_tgt_x <= w_cap_x;
        r_tgt_y <= w_cap_y;
      end
      if (r_state == ST_COMMIT) begin
        r_xpos      <= w_next_x;
        r_ypos      <= w_next_y;
        r_frame_upd <= (w_next_x != r_xpos) || (w_next_y != r_ypos);
      end else begin
        r_frame_upd <= 1'b0;
      end
    end
  end

  assign xpos      = r_xpos;
  assign ypos      = r_ypos;
  assign frame_upd = r_frame_upd;

endmodule

`default_nettype wire

// File: tb/tb_mouse_pos_sync.sv
// tb_mouse_pos_sync: directed checks of two instances (MAX_STEP 512 and 16) sharing one stimulus.
// Rev 1.0
`default_nettype none

module tb_mouse_pos_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] mouse_xpos = '0;
  logic [11:0] mouse_ypos = '0;
  logic        mouse_valid = 1'b0;
  logic [11:0] xb_pos, yb_pos, xs_pos, ys_pos;
  logic        upd_b, upd_s;
  int          n_err = 0;
  int          n_chk = 0;

  vga_if vga_bus ();

  always #5 clk = ~clk;

  mouse_pos_sync #(.H_ACTIVE(1024), .V_ACTIVE(768), .MAX_STEP(512)) dut_big (
    .clk(clk), .rst(rst), .vga_in(vga_bus),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .mouse_valid(mouse_valid),
    .xpos(xb_pos), .ypos(yb_pos), .frame_upd(upd_b)
  );

  mouse_pos_sync #(.H_ACTIVE(1024), .V_ACTIVE(768), .MAX_STEP(16)) dut_small (
    .clk(clk), .rst(rst), .vga_in(vga_bus),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .mouse_valid(mouse_valid),
    .xpos(xs_pos), .ypos(ys_pos), .frame_upd(upd_s)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic mouse(input logic [11:0] mx, input logic [11:0] my);
    mouse_valid = 1'b1;
    mouse_xpos  = mx;
    mouse_ypos  = my;
    tick();
    mouse_valid = 1'b0;
  endtask

  // Returns just after the edge leaving COMMIT; optional sample lands in the COMMIT cycle.
  task automatic frame(input bit mv, input logic [11:0] mx, input logic [11:0] my);
    vga_bus.vblnk = 1'b1;
    tick();
    if (mv) begin
      mouse_valid = 1'b1;
      mouse_xpos  = mx;
      mouse_ypos  = my;
    end
    tick();
    mouse_valid = 1'b0;
  endtask

  task automatic frame_end();
    repeat (2) tick();
    vga_bus.vblnk = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vga_bus.vblnk = 1'b0;
    repeat (3) tick();
    chk("rst_xb", 16'(xb_pos), 16'd0);
    chk("rst_yb", 16'(yb_pos), 16'd0);
    chk("rst_upd_b", 16'(upd_b), 16'd0);
    chk("rst_xs", 16'(xs_pos), 16'd0);
    rst = 1'b1;
    repeat (2) tick();

    // Rate-limited convergence toward (40,5)
    mouse(12'd40, 12'd5);
    chk("hold_active_xb", 16'(xb_pos), 16'd0);
    frame(1'b0, 12'd0, 12'd0);
    chk("f1_xs", 16'(xs_pos), 16'd16);
    chk("f1_ys", 16'(ys_pos), 16'd5);
    chk("f1_upd_s", 16'(upd_s), 16'd1);
    chk("f1_xb", 16'(xb_pos), 16'd40);
    chk("f1_upd_b", 16'(upd_b), 16'd1);
    tick();
    chk("f1_upd_pulse", 16'(upd_s), 16'd0);
    frame_end();
    frame(1'b0, 12'd0, 12'd0);
    chk("f2_xs", 16'(xs_pos), 16'd32);
    chk("f2_upd_b", 16'(upd_b), 16'd0);
    frame_end();
    frame(1'b0, 12'd0, 12'd0);
    chk("f3_xs", 16'(xs_pos), 16'd40);
    chk("f3_ys", 16'(ys_pos), 16'd5);
    chk("f3_upd_s", 16'(upd_s), 16'd1);
    frame_end();
    frame(1'b0, 12'd0, 12'd0);
    chk("f4_xs", 16'(xs_pos), 16'd40);
    chk("f4_upd_s", 16'(upd_s), 16'd0);
    frame_end();

    // Single large jump
    mouse(12'd100, 12'd200);
    chk("hold_active_xb2", 16'(xb_pos), 16'd40);
    frame(1'b0, 12'd0, 12'd0);
    chk("j_xb", 16'(xb_pos), 16'd100);
    chk("j_yb", 16'(yb_pos), 16'd200);
    chk("j_upd_b", 16'(upd_b), 16'd1);
    chk("j_xs", 16'(xs_pos), 16'd56);
    chk("j_ys", 16'(ys_pos), 16'd21);
    frame_end();

    // Last sample before commit wins
    mouse(12'd10, 12'd10);
    mouse(12'd20, 12'd20);
    mouse(12'd30, 12'd30);
    frame(1'b0, 12'd0, 12'd0);
    chk("last_xb", 16'(xb_pos), 16'd30);
    chk("last_yb", 16'(yb_pos), 16'd30);
    chk("last_xs", 16'(xs_pos), 16'd40);
    chk("last_ys", 16'(ys_pos), 16'd30);
    frame_end();

    // Sample in the COMMIT cycle is deferred one frame
    mouse(12'd50, 12'd50);
    frame(1'b0, 12'd0, 12'd0);
    chk("pre_xb", 16'(xb_pos), 16'd50);
    chk("pre_ys", 16'(ys_pos), 16'd46);
    frame_end();
    frame(1'b1, 12'd500, 12'd500);
    chk("cc_xb", 16'(xb_pos), 16'd50);
    chk("cc_yb", 16'(yb_pos), 16'd50);
    chk("cc_upd_b", 16'(upd_b), 16'd0);
    chk("cc_ys", 16'(ys_pos), 16'd50);
    chk("cc_upd_s", 16'(upd_s), 16'd1);
    frame_end();
    frame(1'b0, 12'd0, 12'd0);
    chk("cc2_xb", 16'(xb_pos), 16'd500);
    chk("cc2_yb", 16'(yb_pos), 16'd500);
    chk("cc2_upd_b", 16'(upd_b), 16'd1);
    chk("cc2_xs", 16'(xs_pos), 16'd66);
    frame_end();

    // Edge-of-screen sample, clamped only when the option is built in
    mouse(12'd1020, 12'd760);
    frame(1'b0, 12'd0, 12'd0);
    frame_end();
    frame(1'b0, 12'd0, 12'd0);
`ifdef POS_CLAMP_EN
    chk("edge_xb", 16'(xb_pos), 16'd976);
    chk("edge_yb", 16'(yb_pos), 16'd704);
`else
    chk("edge_xb", 16'(xb_pos), 16'd1020);
    chk("edge_yb", 16'(yb_pos), 16'd760);
`endif
    frame_end();

    // Reset during COMMIT, released while still in blank
    mouse(12'd7, 12'd9);
    vga_bus.vblnk = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("arst_xb", 16'(xb_pos), 16'd0);
    chk("arst_yb", 16'(yb_pos), 16'd0);
    chk("arst_xs", 16'(xs_pos), 16'd0);
    chk("arst_upd_b", 16'(upd_b), 16'd0);
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("midblank_xb", 16'(xb_pos), 16'd0);
    chk("midblank_upd_b", 16'(upd_b), 16'd0);
    vga_bus.vblnk = 1'b0;
    repeat (3) tick();
    chk("post_rst_xb", 16'(xb_pos), 16'd0);
    mouse(12'd7, 12'd9);
    frame(1'b0, 12'd0, 12'd0);
    chk("rec_xb", 16'(xb_pos), 16'd7);
    chk("rec_yb", 16'(yb_pos), 16'd9);
    chk("rec_upd_b", 16'(upd_b), 16'd1);
    chk("rec_xs", 16'(xs_pos), 16'd7);
    frame_end();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
